// File: rtl/reg_file_pkg.sv
// Shared types and limits for the multi-port register file.
package reg_file_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_t;

   localparam int MAX_NR = 8;

endpackage

// File: rtl/reg_file_clr_seq.sv
// Clear sequencer: sweeps every entry to zero after reset or on clr_req, then qualifies user writes.
// Sweep takes 2**PW cycles; user writes and clear requests are ignored while it runs.
module reg_file_clr_seq
   import reg_file_pkg::*;
#(
   parameter int PW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_req,
   input  logic          wr_en,
   output logic          busy,
   output logic          clr_we,
   output logic [PW-1:0] clr_addr,
   output logic          wr_ok
);

   state_t        state_q;
   state_t        state_d;
   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CLEAR;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // ptr wraps to zero naturally on the edge that clears the last entry.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         CLEAR: begin
            ptr_d = ptr_q + PW'(1);
            if (ptr_q == {PW{1'b1}})
               state_d = IDLE;
         end
         IDLE: begin
            if (clr_req) begin
               state_d = CLEAR;
               ptr_d   = '0;
            end
         end
         default: begin
            state_d = CLEAR;
            ptr_d   = '0;
         end
      endcase
   end

   always_comb begin
      busy     = (state_q == CLEAR);
      clr_we   = (state_q == CLEAR);
      clr_addr = ptr_q;
      wr_ok    = (state_q == IDLE) && wr_en && !clr_req;
   end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with hardware clear sweep, optional write bypass and registered write ack.
// Reads are combinational (0 cycles); writes land at the next edge, done follows one cycle later.
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int DW     = 8,
   parameter int PW     = 4,
   parameter int NR     = 2,
   parameter int BYPASS = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_req,
   input  logic             wr_en,
   input  logic [PW-1:0]    wr_addr,
   input  logic [DW-1:0]    dat_in,
   input  logic [NR*PW-1:0] rd_addr,
   output logic [NR*DW-1:0] rd_dat,
   output logic             done,
   output logic             busy
);

   localparam int DEPTH = 1 << PW;

   generate
      if (NR < 1 || NR > MAX_NR) begin : g_bad_nr
         $error("reg_file_mp: NR out of range");
      end
   endgenerate

   logic [DW-1:0] core [DEPTH];
   logic          clr_we;
   logic [PW-1:0] clr_addr;
   logic          wr_ok;

   reg_file_clr_seq #(
      .PW (PW)
   ) u_clr_seq (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_req  (clr_req),
      .wr_en    (wr_en),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr),
      .wr_ok    (wr_ok)
   );

   // Storage is deliberately not reset; the sweep zeroes it instead.
   always_ff @(posedge clk) begin
      if (clr_we)
         core[clr_addr] <= '0;
      else if (wr_ok)
         core[wr_addr] <= dat_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         done <= 1'b0;
      else
         done <= wr_ok;
   end

   genvar k;
   generate
      for (k = 0; k < NR; k++) begin : g_rd
         logic [PW-1:0] addr;
         logic          hit;
         assign addr = rd_addr[k*PW +: PW];
         assign hit  = (BYPASS != 0) && wr_ok && (addr == wr_addr);
         // Array contents are meaningless mid-sweep, so reads are forced to zero.
         assign rd_dat[k*DW +: DW] = busy ? '0 : (hit ? dat_in : core[addr]);
      end
   endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench: two 8x16 instances (bypass on/off) sharing stimulus, plus a 16x32 four-port instance.
module tb_reg_file_mp;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clr_req;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [7:0]  dat_in;
   logic [7:0]  rd_addr;
   logic [15:0] rd_a;
   logic [15:0] rd_b;
   logic        busy_a, busy_b, done_a, done_b;

   logic        w_clr;
   logic        w_wr_en;
   logic [4:0]  w_wr_addr;
   logic [15:0] w_dat_in;
   logic [19:0] w_rd_addr;
   logic [63:0] w_rd;
   logic        w_busy, w_done;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   reg_file_mp #(.DW(8), .PW(4), .NR(2), .BYPASS(1)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .wr_en(wr_en), .wr_addr(wr_addr),
      .dat_in(dat_in), .rd_addr(rd_addr), .rd_dat(rd_a), .done(done_a), .busy(busy_a)
   );

   reg_file_mp #(.DW(8), .PW(4), .NR(2), .BYPASS(0)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .wr_en(wr_en), .wr_addr(wr_addr),
      .dat_in(dat_in), .rd_addr(rd_addr), .rd_dat(rd_b), .done(done_b), .busy(busy_b)
   );

   reg_file_mp #(.DW(16), .PW(5), .NR(4), .BYPASS(1)) u_dut_w (
      .clk(clk), .rst_n(rst_n), .clr_req(w_clr), .wr_en(w_wr_en), .wr_addr(w_wr_addr),
      .dat_in(w_dat_in), .rd_addr(w_rd_addr), .rd_dat(w_rd), .done(w_done), .busy(w_busy)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] wval(input int i);
      logic [7:0] b;
      b = 8'(i);
      return {b ^ 8'h5A, ~b};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int cnt, cnt_w, n;
      logic dseen, rdnz;

      // Reset sweep with a write request held throughout
      rst_n = 1'b0; clr_req = 1'b0;
      wr_en = 1'b1; wr_addr = 4'd2; dat_in = 8'h77; rd_addr = {4'd5, 4'd2};
      w_clr = 1'b0; w_wr_en = 1'b0; w_wr_addr = '0; w_dat_in = '0; w_rd_addr = '0;
      #1;
      chk("rst_busy_a", 64'(busy_a), 64'd1);
      chk("rst_done_a", 64'(done_a), 64'd0);
      chk("rst_rd_a",   64'(rd_a),   64'd0);
      chk("rst_busy_w", 64'(w_busy), 64'd1);
      chk("rst_done_w", 64'(w_done), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i <= 32; i++) begin
         #1;
         chk("sweep_busy_a", 64'(busy_a), 64'(i < 16));
         chk("sweep_busy_w", 64'(w_busy), 64'(i < 32));
         if (i <= 16) chk("sweep_done_a", 64'(done_a), 64'd0);
         if (i < 16) begin
            chk("sweep_rd_a", 64'(rd_a), 64'd0);
            chk("sweep_rd_b", 64'(rd_b), 64'd0);
         end
         if (i < 32) chk("sweep_rd_w", w_rd, 64'd0);
         if (i == 16) begin
            chk("first_wr_bypass_a", 64'(rd_a), 64'h0077);
            chk("first_wr_nobyp_b",  64'(rd_b), 64'h0000);
         end
         if (i == 17) begin
            chk("first_wr_done_a", 64'(done_a), 64'd1);
            chk("first_wr_rd_b",   64'(rd_b),   64'h0077);
         end
         @(negedge clk);
      end
      wr_en = 1'b0;
      #1 chk("b2b_done_held", 64'(done_a), 64'd1);
      @(negedge clk);
      #1 chk("done_drop", 64'(done_a), 64'd0);

      // Basic write/read
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 4'd3; dat_in = 8'hA5; rd_addr = {4'd3, 4'd3};
      #1;
      chk("basic_done_pre", 64'(done_a), 64'd0);
      chk("basic_byp_a",    64'(rd_a),   64'hA5A5);
      chk("basic_old_b",    64'(rd_b),   64'h0000);
      @(negedge clk);
      wr_en = 1'b0;
      #1;
      chk("basic_done",  64'(done_a), 64'd1);
      chk("basic_done_b", 64'(done_b), 64'd1);
      chk("basic_rd_a",  64'(rd_a),   64'hA5A5);
      chk("basic_rd_b",  64'(rd_b),   64'hA5A5);
      @(negedge clk);
      #1 chk("basic_done_end", 64'(done_a), 64'd0);

      // Bypass: port 0 reads the write address, port 1 reads addr 3
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 4'd7; dat_in = 8'h5A; rd_addr = {4'd3, 4'd7};
      #1;
      chk("byp_on_a",  64'(rd_a), 64'hA55A);
      chk("byp_off_b", 64'(rd_b), 64'hA500);
      @(negedge clk);
      wr_en = 1'b0;
      #1;
      chk("byp_next_a", 64'(rd_a), 64'hA55A);
      chk("byp_next_b", 64'(rd_b), 64'hA55A);

      // Clear request colliding with a write; writes held during the sweep are ignored
      @(negedge clk);
      clr_req = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; dat_in = 8'hFF; rd_addr = {4'd9, 4'd0};
      #1 chk("coll_no_bypass", 64'(rd_a), 64'h0000);
      @(negedge clk);
      clr_req = 1'b0; wr_addr = 4'd9; dat_in = 8'h33;
      #1;
      cnt = 0; dseen = 1'b0; rdnz = 1'b0; n = 0;
      while (busy_a === 1'b1 && n < 100) begin
         cnt++; n++;
         if (done_a) dseen = 1'b1;
         if (rd_a != 16'h0) rdnz = 1'b1;
         @(negedge clk);
         #1;
      end
      wr_en = 1'b0;
      #1;
      chk("coll_busy_cycles", 64'(cnt),   64'd16);
      chk("coll_done_seen",   64'(dseen), 64'd0);
      chk("coll_rd_during",   64'(rdnz),  64'd0);
      chk("coll_rd_after",    64'(rd_a),  64'h0000);
      chk("coll_rd_after_b",  64'(rd_b),  64'h0000);

      // Reset in the middle of a clear sweep
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 4'd15; dat_in = 8'h11; rd_addr = {4'd15, 4'd15};
      @(negedge clk);
      wr_en = 1'b0;
      #1 chk("mid_pre_rd", 64'(rd_a), 64'h1111);
      @(negedge clk);
      clr_req = 1'b1;
      @(negedge clk);
      clr_req = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 64'(busy_a), 64'd1);
      chk("mid_rst_done", 64'(done_a), 64'd0);
      chk("mid_rst_rd",   64'(rd_a),   64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      cnt = 0; cnt_w = 0; n = 0;
      while ((busy_a === 1'b1 || w_busy === 1'b1) && n < 100) begin
         n++;
         if (busy_a) cnt++;
         if (w_busy) cnt_w++;
         @(negedge clk);
         #1;
      end
      chk("mid_busy_a", 64'(cnt),   64'd16);
      chk("mid_busy_w", 64'(cnt_w), 64'd32);
      chk("mid_rd15",   64'(rd_a),  64'h0000);
      chk("mid_rd15_b", 64'(rd_b),  64'h0000);

      // Wide instance: fill all entries, read back with rotated addresses, then clear
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         w_wr_en = 1'b1; w_wr_addr = 5'(i); w_dat_in = wval(i);
      end
      @(negedge clk);
      w_wr_en = 1'b0;
      #1 chk("w_done", 64'(w_done), 64'd1);
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         for (int k = 0; k < 4; k++) w_rd_addr[k*5 +: 5] = 5'((i + k) % 32);
         #1;
         for (int k = 0; k < 4; k++)
            chk($sformatf("w_rd_%0d_p%0d", i, k), 64'(w_rd[k*16 +: 16]), 64'(wval((i + k) % 32)));
      end
      @(negedge clk);
      w_clr = 1'b1;
      @(negedge clk);
      w_clr = 1'b0;
      #1;
      cnt_w = 0; n = 0;
      while (w_busy === 1'b1 && n < 100) begin
         cnt_w++; n++;
         @(negedge clk);
         #1;
      end
      chk("w_clr_cycles", 64'(cnt_w), 64'd32);
      w_rd_addr = {5'd31, 5'd17, 5'd1, 5'd0};
      #1 chk("w_clr_rd", w_rd, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
